mem_pair_loader: RTL
====================

MEM_PAIR_LOADER -- requirements
Module: mem_pair_loader

Interface
REQ-001 SHALL have port: clock  input  1  single system clock; all state changes on rising edge.
REQ-002 SHALL have port: clear  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: start  input  1  one-cycle request to begin a load pass.
REQ-004 SHALL have port: s_valid  input  1  source presents a word on s_data.
REQ-005 SHALL have port: s_data  input  4  data word to be stored.
REQ-006 SHALL have port: s_ready  output  1  loader accepts s_data this cycle.
REQ-007 SHALL have ports: mem_a_ena, mem_a_wea  output  1 each  enable and write-enable for memory A.
REQ-008 SHALL have ports: mem_a_addr  output  3, and mem_a_din  output  4  address and write data for memory A.
REQ-009 SHALL have ports mem_b_ena, mem_b_wea, mem_b_addr, mem_b_din with the same widths and meanings as REQ-007/008, for memory B.
REQ-010 SHALL have port: busy  output  1  high in LOAD.
REQ-011 SHALL have port: done  output  1  one-cycle pulse when a pass completes.
REQ-012 SHALL have port: checksum  output  8  sum of all words written this pass.

Function
REQ-013 SHALL implement FSM states IDLE, LOAD and DONE.
REQ-014 SHALL move IDLE->LOAD on start; start SHALL be ignored in LOAD.
REQ-015 SHALL make the transition LOAD->DONE the cycle after the 16th accepted word; DONE->IDLE SHALL occur unconditionally one cycle later.
REQ-016 SHALL drive s_ready high only in LOAD; a handshake occurs when s_valid and s_ready are both high at a rising edge.
REQ-017 SHALL give s_data no effect while s_ready is low; s_valid with start in IDLE SHALL NOT be accepted that cycle.
REQ-018 SHALL route accepted words alternately: even-indexed word (0,2,..14) -> memory A, odd-indexed -> memory B.
REQ-019 SHALL write words 2k and 2k+1 to address k; the 3-bit address SHALL increment after each B write and wrap 7->0 at pass end.
REQ-020 SHALL register the write strobes: ena, wea, addr and din are asserted exactly one cycle after the handshake, for one cycle, on the selected memory only.
REQ-021 SHALL hold mem_x_ena=0 and mem_x_wea=0 when no write is issued; addr/din are don't-care then.
REQ-022 SHALL accept at most one word per cycle; sustained s_valid SHALL complete a pass in 16 cycles.
REQ-023 SHALL clear checksum to 0 on entry to LOAD and add each accepted word zero-extended to 8 bits; the maximum value 240 SHALL never wrap.
REQ-024 SHALL hold checksum stable from the DONE state until the next start.
REQ-025 SHALL assert done for exactly the one cycle spent in DONE; busy SHALL be high only in LOAD.
REQ-026 SHALL let a start arriving in DONE begin no new pass (it is ignored); a start in the following IDLE cycle SHALL be honoured.

Reset
REQ-027 SHALL force, on clear asserted at any time: state=IDLE, word index=0, address=0, checksum=0, s_ready=0, busy=0, done=0, all ena/wea=0, addr=0, din=0.
REQ-028 SHALL, on clear mid-pass, suppress any pending registered write immediately; memory contents SHALL then be unspecified and require a new pass.
REQ-029 SHALL take the first start on the first rising edge after clear deasserts.

Structure
REQ-030 SHALL take MEM_DEPTH=8, ADDR_W=3, DATA_W=4, WORDS_PER_PASS=16, CSUM_W=8 and the state enumeration from the shared package loader_pkg.
REQ-031 SHALL implement as one module with no sub-modules; the memories are external block-memory instances that this block drives.

Verification
REQ-032 SHALL cover: clear, start, then 16 consecutive words 1..15,0 -> A addr0..7 = 1,3,..,15; B = 2,4,..,14,0; done at cycle 17; checksum=120.
REQ-033 SHALL cover: s_valid toggling 1,0 during a pass -> exactly 16 writes; no ena pulse in idle gaps; final addresses match REQ-019.
REQ-034 SHALL cover: all words 15 -> checksum=240 with no overflow.
REQ-035 SHALL cover: clear asserted after 5 words -> wea drops the same cycle, state IDLE, checksum=0; a new 16-word pass then completes correctly.
REQ-036 SHALL cover: start with s_valid=1 in IDLE -> no write that cycle; start pulsed again mid-LOAD and in DONE -> no effect on count or address.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared sizing, state encoding and checksum helper for the paired-memory loader.
// One pass writes WORDS_PER_PASS words across two MEM_DEPTH-deep memories.
package loader_pkg;

   localparam int MEM_DEPTH      = 8;
   localparam int ADDR_W         = 3;
   localparam int DATA_W         = 4;
   localparam int WORDS_PER_PASS = 16;
   localparam int CSUM_W         = 8;
   localparam int IDX_W          = $clog2(WORDS_PER_PASS);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } state_t;

   // 8-bit accumulator cannot wrap: 16 words of at most 15 sum to 240.
   function automatic logic [CSUM_W-1:0] csum_add(input logic [CSUM_W-1:0] acc,
                                                  input logic [DATA_W-1:0] w);
      return acc + {{(CSUM_W-DATA_W){1'b0}}, w};
   endfunction

endpackage

// File: rtl/mem_pair_loader.sv
// Streams 16 source words into two external block memories, even words to A and
// odd words to B at a shared address, with registered write strobes and a checksum.
module mem_pair_loader
   import loader_pkg::*;
(
   input  logic              clock,
   input  logic              clear,
   input  logic              start,
   input  logic              s_valid,
   input  logic [DATA_W-1:0] s_data,
   output logic              s_ready,
   output logic              mem_a_ena,
   output logic              mem_a_wea,
   output logic [ADDR_W-1:0] mem_a_addr,
   output logic [DATA_W-1:0] mem_a_din,
   output logic              mem_b_ena,
   output logic              mem_b_wea,
   output logic [ADDR_W-1:0] mem_b_addr,
   output logic [DATA_W-1:0] mem_b_din,
   output logic              busy,
   output logic              done,
   output logic [CSUM_W-1:0] checksum
);

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    idx_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [CSUM_W-1:0]   csum_q;
   logic                load_entry;
   logic                hs_p0;
   logic                odd_p0;

   logic                vld_a_p1, vld_b_p1;
   logic [ADDR_W-1:0]   addr_a_p1, addr_b_p1;
   logic [DATA_W-1:0]   din_a_p1, din_b_p1;

   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      s_ready    = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      load_entry = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d    = LOAD;
               load_entry = 1'b1;
            end
         end
         LOAD: begin
            s_ready = 1'b1;
            busy    = 1'b1;
            if (s_valid && (idx_q == IDX_W'(WORDS_PER_PASS - 1))) begin
               state_d = DONE;
            end
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign hs_p0  = s_valid & s_ready;
   assign odd_p0 = idx_q[0];

   // p0: handshake updates word index, shared address and running checksum
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         idx_q  <= '0;
         addr_q <= '0;
         csum_q <= '0;
      end else if (load_entry) begin
         idx_q  <= '0;
         addr_q <= '0;
         csum_q <= '0;
      end else if (hs_p0) begin
         idx_q  <= idx_q + IDX_W'(1);
         csum_q <= csum_add(csum_q, s_data);
         if (odd_p0) begin
            addr_q <= addr_q + ADDR_W'(1);
         end
      end
   end

   // p1: one-cycle write strobe to the selected memory; clear kills a pending write
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         vld_a_p1  <= 1'b0;
         vld_b_p1  <= 1'b0;
         addr_a_p1 <= '0;
         addr_b_p1 <= '0;
         din_a_p1  <= '0;
         din_b_p1  <= '0;
      end else begin
         vld_a_p1 <= hs_p0 & ~odd_p0;
         vld_b_p1 <= hs_p0 & odd_p0;
         if (hs_p0 && !odd_p0) begin
            addr_a_p1 <= addr_q;
            din_a_p1  <= s_data;
         end
         if (hs_p0 && odd_p0) begin
            addr_b_p1 <= addr_q;
            din_b_p1  <= s_data;
         end
      end
   end

   assign mem_a_ena  = vld_a_p1;
   assign mem_a_wea  = vld_a_p1;
   assign mem_a_addr = addr_a_p1;
   assign mem_a_din  = din_a_p1;
   assign mem_b_ena  = vld_b_p1;
   assign mem_b_wea  = vld_b_p1;
   assign mem_b_addr = addr_b_p1;
   assign mem_b_din  = din_b_p1;
   assign checksum   = csum_q;

endmodule
